wrr_arbiter8: RTL and testbench

WRR_ARBITER8 -- requirements
Module: wrr_arbiter8

---
 rtl/wrr_arbiter8_if.sv | 26 ++
 rtl/wrr_arbiter8.sv | 107 ++++++++++
 tb/tb_wrr_arbiter8.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/wrr_arbiter8_if.sv
// Request/config/grant bundle of the weighted round-robin arbiter.
// The master drives requests and weight writes; the slave (arbiter) drives the grant.
interface wrr_arbiter8_if #(
    parameter int N  = 8,
    parameter int WW = 3
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [WW-1:0] cfg_weight;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic          grant_valid;

    modport master (
        output req, cfg_we, cfg_idx, cfg_weight,
        input  grant, grant_id, grant_valid
    );

    modport slave (
        input  req, cfg_we, cfg_idx, cfg_weight,
        output grant, grant_id, grant_valid
    );
endinterface

// File: rtl/wrr_arbiter8.sv
// Weighted round-robin arbiter: requester i may hold the grant for up to
// weight[i]+1 consecutive cycles, then the search restarts after it.
module wrr_arbiter8 #(
    parameter int N  = 8,
    parameter int WW = 3
) (
    input logic           clk,
    input logic           rst,
    wrr_arbiter8_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] weight_q [N];
    logic [IW-1:0] last_q, last_d;
    logic [WW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] gid_q, gid_d;

    logic          found;
    logic [IW-1:0] sel;
    logic [IW-1:0] scanIdx;
    logic          load;

    // In GRANT the owner is always last_q, so one scan serves both idle and release.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        scanIdx = '0;
        for (int k = 1; k <= N; k++) begin
            scanIdx = IW'((int'(last_q) + k) % N);
            if (!found && bus.req[scanIdx]) begin
                found = 1'b1;
                sel   = scanIdx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) load = 1'b1;
            end
            GRANT: begin
                if (bus.req[last_q] && (cnt_q != '0)) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (found) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    gid_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Weight is read pre-edge, so a same-edge cfg write to sel loads the old value.
        if (load) begin
            state_d = GRANT;
            grant_d = {{(N-1){1'b0}}, 1'b1} << sel;
            gid_d   = sel;
            cnt_d   = weight_q[sel];
            last_d  = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= IW'(N - 1);
            cnt_q   <= '0;
            grant_q <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) weight_q[k] <= '0;
        end else if (bus.cfg_we) begin
            weight_q[bus.cfg_idx] <= bus.cfg_weight;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = gid_q;
    assign bus.grant_valid = |grant_q;
endmodule

// File: tb/tb_wrr_arbiter8.sv
// Bench for wrr_arbiter8: directed scenarios with literal expectations, then
// random traffic checked every cycle against an owner/turn-length model.
module tb_wrr_arbiter8;
    localparam int N  = 8;
    localparam int WW = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wrr_arbiter8_if #(.N(N), .WW(WW)) bus ();

    wrr_arbiter8 #(.N(N), .WW(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: who owns, how many cycles of this turn are used, how long the turn may be.
    int mOwner, mLast, mHeld, mQuota;
    int mWeights [N];
    int nOwner, nLast, nHeld, nQuota;
    int c;

    always_comb begin
        nOwner = mOwner;
        nLast  = mLast;
        nHeld  = mHeld;
        nQuota = mQuota;
        c      = 0;
        if (mOwner >= 0 && (((bus.req >> mOwner) & 8'd1) != 8'd0) && mHeld < mQuota) begin
            nHeld = mHeld + 1;
        end else begin
            nOwner = -1;
            for (int k = 1; k <= N; k++) begin
                c = (mLast + k) % N;
                if (nOwner < 0 && (((bus.req >> c) & 8'd1) != 8'd0)) begin
                    nOwner = c;
                    nLast  = c;
                    nHeld  = 1;
                    nQuota = mWeights[3'(c)] + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            mOwner <= -1;
            mLast  <= N - 1;
            mHeld  <= 0;
            mQuota <= 0;
            for (int k = 0; k < N; k++) mWeights[k] <= 0;
        end else begin
            mOwner <= nOwner;
            mLast  <= nLast;
            mHeld  <= nHeld;
            mQuota <= nQuota;
            if (bus.cfg_we) mWeights[bus.cfg_idx] <= int'(bus.cfg_weight);
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after a falling edge, return at the next falling edge.
    task automatic applyStimulus(input logic rstv, input logic [7:0] reqv,
                                 input logic we, input logic [2:0] idx, input logic [2:0] w);
        rst            = rstv;
        bus.req        = reqv;
        bus.cfg_we     = we;
        bus.cfg_idx    = idx;
        bus.cfg_weight = w;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        checkOutput("model_grant", bus.grant, (mOwner < 0) ? 8'h00 : (8'h01 << mOwner));
        checkOutput("model_grant_id", 8'(bus.grant_id), (mOwner < 0) ? 8'h00 : 8'(mOwner));
        checkOutput("model_grant_valid", 8'(bus.grant_valid), (mOwner < 0) ? 8'h00 : 8'h01);
    end

    logic [7:0] expG;
    logic [7:0] rq;
    logic       rv;

    initial begin
        checks = 0;
        errors = 0;
        rst            = 1'b0;
        bus.req        = 8'hFF;
        bus.cfg_we     = 1'b0;
        bus.cfg_idx    = 3'd0;
        bus.cfg_weight = 3'd0;

        // Reset held with all requesting, then first grant searches from 0.
        applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 3'd0);
        applyStimulus(1'b0, 8'hFF, 1'b0, 3'd0, 3'd0);
        checkOutput("reset_grant", bus.grant, 8'h00);
        checkOutput("reset_valid", 8'(bus.grant_valid), 8'h00);
        checkOutput("reset_id", 8'(bus.grant_id), 8'h00);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, 8'hFF, 1'b0, 3'd0, 3'd0);
            expG = 8'h01 << (k % 8);
            checkOutput("rr_all_weight0", bus.grant, expG);
        end
        checkOutput("rr_wrap_id", 8'(bus.grant_id), 8'h00);

        // weight[2]=3 with requesters 2 and 4.
        applyStimulus(1'b1, 8'h00, 1'b1, 3'd2, 3'd3);
        checkOutput("release_to_idle", bus.grant, 8'h00);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 8'h14, 1'b0, 3'd0, 3'd0);
            expG = ((k % 5) == 4) ? 8'h10 : 8'h04;
            checkOutput("weighted_2_4", bus.grant, expG);
        end

        // Lone requester with weight 0 keeps the grant without a gap.
        applyStimulus(1'b1, 8'h00, 1'b0, 3'd0, 3'd0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'h08, 1'b0, 3'd0, 3'd0);
            checkOutput("lone_req3", bus.grant, 8'h08);
        end
        applyStimulus(1'b1, 8'h00, 1'b0, 3'd0, 3'd0);
        checkOutput("lone_drop", bus.grant, 8'h00);

        // weight[0]=7, requester 0 drops its request after two owned cycles.
        applyStimulus(1'b1, 8'h00, 1'b1, 3'd0, 3'd7);
        applyStimulus(1'b1, 8'h21, 1'b0, 3'd0, 3'd0);
        checkOutput("early_drop_first", bus.grant, 8'h20);
        applyStimulus(1'b1, 8'h21, 1'b0, 3'd0, 3'd0);
        checkOutput("early_drop_own1", bus.grant, 8'h01);
        applyStimulus(1'b1, 8'h21, 1'b0, 3'd0, 3'd0);
        checkOutput("early_drop_own2", bus.grant, 8'h01);
        applyStimulus(1'b1, 8'h20, 1'b0, 3'd0, 3'd0);
        checkOutput("early_drop_handoff", bus.grant, 8'h20);

        // Weight rewrite mid-turn only affects the following turn of requester 1.
        applyStimulus(1'b1, 8'h00, 1'b1, 3'd1, 3'd7);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b1, 8'h06, (k == 2), 3'd1, 3'd2);
            expG = (k < 8) ? 8'h02 : ((k < 12) ? 8'h04 : 8'h02);
            checkOutput("midturn_rewrite", bus.grant, expG);
        end

        // Reset during a weighted grant clears weights and beats a same-edge write.
        applyStimulus(1'b1, 8'h00, 1'b1, 3'd4, 3'd5);
        applyStimulus(1'b1, 8'h10, 1'b0, 3'd0, 3'd0);
        applyStimulus(1'b1, 8'h10, 1'b0, 3'd0, 3'd0);
        checkOutput("pre_reset_owner4", bus.grant, 8'h10);
        applyStimulus(1'b0, 8'h10, 1'b1, 3'd0, 3'd7);
        checkOutput("midgrant_reset", bus.grant, 8'h00);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, 8'hFF, 1'b0, 3'd0, 3'd0);
            expG = 8'h01 << (k % 8);
            checkOutput("post_reset_rr", bus.grant, expG);
        end

        // Random traffic with occasional weight writes and resets.
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 3))
                0:       rq = 8'($urandom) & 8'($urandom);
                1:       rq = 8'h01 << $urandom_range(0, 7);
                2:       rq = 8'hFF;
                default: rq = 8'($urandom);
            endcase
            rv = ($urandom_range(0, 199) != 0);
            applyStimulus(rv, rq, ($urandom_range(0, 7) == 0),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
